alu_share_arbiter: RTL and testbench

Shares one combinational 32-bit ALU (`alu_32_bit`) between two requesters: port 0 (integer execute) and port 1 (branch/address unit). Each requester has a valid/ready handshake. The block does round-robin arbitration, drives the ALU with the winning operands, and captures the result in a single registered response slot with its own valid/ready handshake. Sustained throughput is one operation per cycle; latency is one cycle.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_32_bit.sv | 50 +++++
 rtl/alu_share_arbiter.sv | 119 +++++++++++
 tb/tb_alu_share_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode and width definitions
// Purpose: opcode encodings and datapath width shared by the ALU and its arbiter.
// Ports: none (package).
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SLL  = 4'h1;
  localparam logic [3:0] OP_SLT  = 4'h2;
  localparam logic [3:0] OP_SLTU = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SRL  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_BLT  = 4'hB;
  localparam logic [3:0] OP_BGE  = 4'hC;
  localparam logic [3:0] OP_SRA  = 4'hD;
  localparam logic [3:0] OP_BLTU = 4'hE;
  localparam logic [3:0] OP_BGEU = 4'hF;

endpackage

// File: rtl/alu_32_bit.sv
// rtl/alu_32_bit.sv - combinational 32-bit ALU
// Purpose: purely combinational ALU; every opcode is defined.
// Ports:
//   op_i   opcode (alu_pkg OP_*)
//   in1_i  first operand
//   in2_i  second operand; shifts use in2_i[3:0] only
//   out_o  result; branch opcodes return 0 or 1
module alu_32_bit
  import alu_pkg::*;
(
  input  logic [3:0]       op_i,
  input  logic [ALU_W-1:0] in1_i,
  input  logic [ALU_W-1:0] in2_i,
  output logic [ALU_W-1:0] out_o
);

  logic [3:0] shamt;
  logic       lt_s;
  logic       lt_u;
  logic       eq;

  assign shamt = in2_i[3:0];
  assign lt_s  = $signed(in1_i) < $signed(in2_i);
  assign lt_u  = in1_i < in2_i;
  assign eq    = in1_i == in2_i;

  always_comb begin
    out_o = '0;
    unique case (op_i)
      OP_ADD:  out_o = in1_i + in2_i;
      OP_SLL:  out_o = in1_i << shamt;
      OP_SLT:  out_o = {{(ALU_W-1){1'b0}}, lt_s};
      OP_SLTU: out_o = {{(ALU_W-1){1'b0}}, lt_u};
      OP_XOR:  out_o = in1_i ^ in2_i;
      OP_SRL:  out_o = in1_i >> shamt;
      OP_OR:   out_o = in1_i | in2_i;
      OP_AND:  out_o = in1_i & in2_i;
      OP_SUB:  out_o = in1_i - in2_i;
      OP_BEQ:  out_o = {{(ALU_W-1){1'b0}}, eq};
      OP_BNE:  out_o = {{(ALU_W-1){1'b0}}, !eq};
      OP_BLT:  out_o = {{(ALU_W-1){1'b0}}, lt_s};
      OP_BGE:  out_o = {{(ALU_W-1){1'b0}}, !lt_s};
      OP_SRA:  out_o = $unsigned($signed(in1_i) >>> shamt);
      OP_BLTU: out_o = {{(ALU_W-1){1'b0}}, lt_u};
      OP_BGEU: out_o = {{(ALU_W-1){1'b0}}, !lt_u};
      default: out_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
// Purpose: arbitrate two valid/ready requesters onto a single combinational ALU
//          and capture the result in one registered response slot.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   reqN_valid/ready                requester N handshake (N = 0, 1)
//   reqN_op/a/b/tag                 requester N opcode, operands, opaque tag
//   rsp_valid/ready                 response slot handshake
//   rsp_id, rsp_result, rsp_tag     issuing port, registered ALU result, tag
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [ALU_W-1:0] req0_a,
  input  logic [ALU_W-1:0] req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [ALU_W-1:0] req1_a,
  input  logic [ALU_W-1:0] req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [ALU_W-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag
);

  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [ALU_W-1:0] rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  logic             any_valid;
  logic             grant_id;
  logic             slot_free;
  logic             accept;
  logic [3:0]       alu_op;
  logic [ALU_W-1:0] alu_in1;
  logic [ALU_W-1:0] alu_in2;
  logic [ALU_W-1:0] alu_out;

  // On a tie the port that did not win last time goes; otherwise the lone
  // valid port wins. With no request grant_id is 0, which also parks the ALU
  // mux on port 0.
  always_comb begin
    any_valid = req0_valid || req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = !last_grant_q;
    end else begin
      grant_id = req1_valid;
    end
  end

  // A held result may drain and be replaced in the same cycle.
  assign slot_free  = !rsp_valid_q || rsp_ready;
  assign accept     = any_valid && slot_free;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  assign alu_op  = grant_id ? req1_op : req0_op;
  assign alu_in1 = grant_id ? req1_a  : req0_a;
  assign alu_in2 = grant_id ? req1_b  : req0_b;

  alu_32_bit u_alu (
    .op_i  (alu_op),
    .in1_i (alu_in1),
    .in2_i (alu_in2),
    .out_o (alu_out)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    if (accept) begin
      last_grant_d = grant_id;
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_id;
      rsp_result_d = alu_out;
      rsp_tag_d    = grant_id ? req1_tag : req0_tag;
    end else if (rsp_valid_q && rsp_ready) begin
      // Payload fields keep their last values after a plain drain.
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_tag, req1_tag;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: one response slot plus the round-robin pointer.
  logic        m_valid;
  logic [31:0] m_res;
  logic        m_id;
  logic [3:0]  m_tag;
  logic        m_last;
  logic        acc0, acc1;

  alu_share_arbiter #(.TAG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_tag   (req1_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 16);
    case (op)
      4'h0: return a + b;
      4'h1: return a << sh;
      4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3: return (a < b) ? 32'd1 : 32'd0;
      4'h4: return a ^ b;
      4'h5: return a >> sh;
      4'h6: return a | b;
      4'h7: return a & b;
      4'h8: return a - b;
      4'h9: return (a == b) ? 32'd1 : 32'd0;
      4'hA: return (a != b) ? 32'd1 : 32'd0;
      4'hB: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'hD: return $unsigned($signed(a) >>> sh);
      4'hE: return (a < b) ? 32'd1 : 32'd0;
      default: return (a >= b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_res   = 32'd0;
    m_id    = 1'b0;
    m_tag   = 4'd0;
    m_last  = 1'b1;
  endtask

  // Inputs are already driven (just after a falling edge). Checks outputs
  // against the model, advances one clock, then updates the model.
  task automatic cycle();
    logic free, any, win;
    #1;
    free = !m_valid || rsp_ready;
    any  = req0_valid || req1_valid;
    if (req0_valid && req1_valid) win = !m_last;
    else                          win = req1_valid;
    check("req0_ready", 32'(req0_ready), 32'(free && any && !win));
    check("req1_ready", 32'(req1_ready), 32'(free && any && win));
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      check("rsp_result", rsp_result, m_res);
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_tag", 32'(rsp_tag), 32'(m_tag));
    end
    acc0 = 1'b0;
    acc1 = 1'b0;
    @(posedge clk);
    if (free && any) begin
      m_valid = 1'b1;
      m_id    = win;
      m_last  = win;
      m_res   = win ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
      m_tag   = win ? req1_tag : req0_tag;
      acc0    = !win;
      acc1    = win;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_tag = t;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_tag = t;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 20));
      1:       return 32'h8000_0000 | 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set0(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
    set1(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
    model_reset();
    acc0 = 1'b0;
    acc1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_tag", 32'(rsp_tag), 32'd0);
    rst_n = 1'b1;

    // Idle, then a single add on port 0.
    cycle();
    set0(1'b1, 4'h0, 32'd5, 32'd7, 4'd3);
    cycle();
    set0(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
    #1;
    check("add_result", rsp_result, 32'd12);
    check("add_id", 32'(rsp_id), 32'd0);
    check("add_tag", 32'(rsp_tag), 32'd3);
    cycle();

    // Both ports valid each cycle: grants alternate, one result per cycle.
    set0(1'b1, 4'h8, 32'd10, 32'd3, 4'd1);
    set1(1'b1, 4'h9, 32'd4, 32'd4, 4'd2);
    for (int i = 0; i < 6; i++) cycle();

    // Stall three cycles with a result held, then drain and refill together.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rsp_ready = 1'b1;
    cycle();
    check("refill_valid", 32'(rsp_valid), 32'd1);
    set0(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
    set1(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
    cycle();
    cycle();

    // Arithmetic shift on port 1 alone, then a tie must go to port 0.
    set1(1'b1, 4'hD, 32'h8000_0000, 32'd4, 4'd9);
    cycle();
    set1(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
    #1;
    check("sra_result", rsp_result, 32'hF800_0000);
    check("sra_id", 32'(rsp_id), 32'd1);
    set0(1'b1, 4'h6, 32'h0F, 32'hF0, 4'd4);
    set1(1'b1, 4'h4, 32'hFF, 32'h0F, 4'd5);
    #1;
    check("tie_after_p1", 32'(req0_ready), 32'd1);
    cycle();

    // Asynchronous reset in the middle of the low phase with a result held.
    check("pre_reset_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_result", rsp_result, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("tie_after_reset", 32'(req0_ready), 32'd1);
    check("tie_after_reset_p1", 32'(req1_ready), 32'd0);
    cycle();
    acc0 = 1'b1;
    acc1 = 1'b1;

    // Random traffic; a valid request and its operands stay put until accepted.
    for (int i = 0; i < 3000; i++) begin
      if (!req0_valid || acc0)
        set0(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_operand(), rand_operand(), 4'($urandom_range(0, 15)));
      if (!req1_valid || acc1)
        set1(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_operand(), rand_operand(), 4'($urandom_range(0, 15)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
